// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the active-high hex glyph table and the all-off pattern.
package seg_scan_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-high, before pin polarity is applied.
   localparam logic [7:0] SEG_OFF = 8'h00;

   // Index n holds the {g,f,e,d,c,b,a} glyph for hex digit n; listed 15 down to 0.
   localparam logic [15:0][6:0] GLYPH_TBL = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/seg_scan_driver_hex_seg_decode.sv
// Combinational hex nibble to active-high seven-segment glyph (bit0 = segment a).
module hex_seg_decode
   import seg_scan_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] glyph
);

   assign glyph = GLYPH_TBL[nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with leading-zero blanking, dead time and
// frame-boundary update buffering. Optional blinking is built when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int DEAD           = 2,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
`ifdef SEG_SCAN_BLINK_EN
   ,
   parameter int BLINK_FRAMES   = 64
`endif
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_start
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [7:0] SEG_RST = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF =
      (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [PW-1:0]                 presc_q, presc_d;
   logic [IW-1:0]                 idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]    sh_val_q, sh_val_d, act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0]         sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
   logic                          sh_blz_q, sh_blz_d, act_blz_q, act_blz_d;
   logic                          pend_q, pend_d;
   logic                          bnd_q, bnd_d;
   logic [7:0]                    seg_q, seg_d;
   logic [NUM_DIGITS-1:0]         dig_q, dig_d;
   logic                          fs_q, fs_d;

   logic                          wrap, boundary, in_dead, keep, blank_cur, dp_cur;
   logic [NUM_DIGITS-1:0]         blank_vec, dig_raw;
   logic [3:0]                    nib;
   logic [6:0]                    glyph;
   logic [7:0]                    seg_raw;

`ifdef SEG_SCAN_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BF_LAST = BW'(BLINK_FRAMES - 1);

   logic [NUM_DIGITS-1:0] sh_blk_q, sh_blk_d, act_blk_q, act_blk_d;
   logic [BW-1:0]         bfc_q, bfc_d;
   logic                  bon_q, bon_d;
`endif

   assign wrap     = (presc_q == PRE_LAST);
   assign boundary = wrap && (idx_q == IDX_LAST);

   generate
      if (DEAD > 0) begin : g_dead
         localparam logic [PW-1:0] DEAD_P = PW'(DEAD);
         assign in_dead = (presc_q < DEAD_P);
      end else begin : g_no_dead
         assign in_dead = 1'b0;
      end
   endgenerate

   always_comb begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
   end

   // A load on the boundary cycle goes straight to active so it is never a frame late.
   always_comb begin
      sh_val_d  = sh_val_q;
      sh_dp_d   = sh_dp_q;
      sh_blz_d  = sh_blz_q;
      act_val_d = act_val_q;
      act_dp_d  = act_dp_q;
      act_blz_d = act_blz_q;
      pend_d    = pend_q;
      if (load) begin
         sh_val_d = value;
         sh_dp_d  = dp_in;
         sh_blz_d = blank_lz;
         pend_d   = 1'b1;
      end
      if (boundary) begin
         pend_d = 1'b0;
         if (load) begin
            act_val_d = value;
            act_dp_d  = dp_in;
            act_blz_d = blank_lz;
         end else if (pend_q) begin
            act_val_d = sh_val_q;
            act_dp_d  = sh_dp_q;
            act_blz_d = sh_blz_q;
         end
      end
   end

`ifdef SEG_SCAN_BLINK_EN
   always_comb begin
      sh_blk_d  = load ? blink_mask : sh_blk_q;
      act_blk_d = act_blk_q;
      if (boundary) begin
         if (load)        act_blk_d = blink_mask;
         else if (pend_q) act_blk_d = sh_blk_q;
      end
      bfc_d = bfc_q;
      bon_d = bon_q;
      if (boundary) begin
         if (bfc_q == BF_LAST) begin
            bfc_d = '0;
            bon_d = ~bon_q;
         end else begin
            bfc_d = bfc_q + 1'b1;
         end
      end
   end
`endif

   // Walk from the most significant digit down; blanking ends at the first visible content.
   always_comb begin
      keep      = 1'b0;
      blank_vec = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         keep         = keep | (act_val_q[i] != 4'h0) | act_dp_q[i];
         blank_vec[i] = act_blz_q & ~keep;
      end
   end

   assign nib       = act_val_q[idx_q];
   assign dp_cur    = act_dp_q[idx_q];
   assign blank_cur = blank_vec[idx_q];

   hex_seg_decode u_dec (
      .nib   (nib),
      .glyph (glyph)
   );

   always_comb begin
      seg_raw = SEG_OFF;
      if (!blank_cur) begin
         seg_raw[SEG_A]  = glyph[0];
         seg_raw[SEG_B]  = glyph[1];
         seg_raw[SEG_C]  = glyph[2];
         seg_raw[SEG_D]  = glyph[3];
         seg_raw[SEG_E]  = glyph[4];
         seg_raw[SEG_F]  = glyph[5];
         seg_raw[SEG_G]  = glyph[6];
         seg_raw[SEG_DP] = dp_cur;
      end
      dig_raw = in_dead ? '0 : (NUM_DIGITS'(1) << idx_q);
`ifdef SEG_SCAN_BLINK_EN
      if (!bon_q && act_blk_q[idx_q]) dig_raw = '0;
`endif
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      dig_d = (DIG_ACTIVE_LOW != 0) ? ~dig_raw : dig_raw;
      bnd_d = boundary;
      fs_d  = bnd_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q   <= '0;
         idx_q     <= '0;
         sh_val_q  <= '0;
         sh_dp_q   <= '0;
         sh_blz_q  <= 1'b0;
         act_val_q <= '0;
         act_dp_q  <= '0;
         act_blz_q <= 1'b0;
         pend_q    <= 1'b0;
         bnd_q     <= 1'b0;
         seg_q     <= SEG_RST;
         dig_q     <= DIG_OFF;
         fs_q      <= 1'b0;
`ifdef SEG_SCAN_BLINK_EN
         sh_blk_q  <= '0;
         act_blk_q <= '0;
         bfc_q     <= '0;
         bon_q     <= 1'b1;
`endif
      end else begin
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         sh_val_q  <= sh_val_d;
         sh_dp_q   <= sh_dp_d;
         sh_blz_q  <= sh_blz_d;
         act_val_q <= act_val_d;
         act_dp_q  <= act_dp_d;
         act_blz_q <= act_blz_d;
         pend_q    <= pend_d;
         bnd_q     <= bnd_d;
         seg_q     <= seg_d;
         dig_q     <= dig_d;
         fs_q      <= fs_d;
`ifdef SEG_SCAN_BLINK_EN
         sh_blk_q  <= sh_blk_d;
         act_blk_q <= act_blk_d;
         bfc_q     <= bfc_d;
         bon_q     <= bon_d;
`endif
      end
   end

   assign seg         = seg_q;
   assign dig_sel     = dig_q;
   assign frame_start = fs_q;

endmodule
